// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory address, 1/2-byte capture and decoder handshake.
// Optional HALT opcode (8'hFF) and halted port enabled by defining IFETCH_HALT_EN.
module instr_fetch_unit #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter int unsigned LONG_OP_BIT = 7
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    input  logic       br_valid,
    input  logic [7:0] br_target,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_op,
    output logic [7:0] instr_imm,
    output logic [7:0] instr_pc,
`ifdef IFETCH_HALT_EN
    output logic       halted,
`endif
    output logic       instr_long
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_OPL  = 3'd1,
        S_IML  = 3'd2,
        S_OUT  = 3'd3,
        S_HALT = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] op_q, op_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [AW-1:0] ipc_q, ipc_d;
    logic          long_q, long_d;
    logic          halted_q, halted_d;

    logic          accept_c;
    logic          rdata_long_c;
    logic          halt_op_c;

    assign accept_c = valid_q & instr_ready;

    // Opcode classification; HALT is forced short when the feature is built in.
`ifdef IFETCH_HALT_EN
    assign halt_op_c    = (op_q == 8'hFF);
    assign rdata_long_c = mem_rdata[LONG_OP_BIT] & (mem_rdata != 8'hFF);
`else
    assign halt_op_c    = 1'b0;
    assign rdata_long_c = mem_rdata[LONG_OP_BIT];
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_OP;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            op_q     <= '0;
            imm_q    <= '0;
            ipc_q    <= '0;
            long_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            op_q     <= op_d;
            imm_q    <= imm_d;
            ipc_q    <= ipc_d;
            long_q   <= long_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic; a redirect overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OP:    state_d = S_OPL;
            S_OPL:   state_d = rdata_long_c ? S_IML : S_OUT;
            S_IML:   state_d = S_OUT;
            S_OUT: begin
                if (accept_c) state_d = halt_op_c ? S_HALT : S_OP;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_OP;
        endcase
        if (br_valid) state_d = S_OP;
    end

    // Memory address and datapath next values.
    always_comb begin
        mem_addr = pc_q;
        pc_d     = pc_q;
        op_d     = op_q;
        imm_d    = imm_q;
        ipc_d    = ipc_q;
        long_d   = long_q;
        valid_d  = (state_d == S_OUT);
        halted_d = (state_d == S_HALT);
        case (state_q)
            S_OPL: begin
                mem_addr = AW'(pc_q + AW'(1));
                op_d     = mem_rdata;
                ipc_d    = pc_q;
                long_d   = rdata_long_c;
                if (!rdata_long_c) imm_d = '0;
            end
            S_IML: imm_d = mem_rdata;
            S_OUT: begin
                if (accept_c) pc_d = AW'(pc_q + (long_q ? AW'(2) : AW'(1)));
            end
            default: ;
        endcase
        // Redirect discards any partially captured instruction.
        if (br_valid) begin
            pc_d   = br_target;
            op_d   = op_q;
            imm_d  = imm_q;
            ipc_d  = ipc_q;
            long_d = long_q;
        end
    end

    assign instr_valid = valid_q;
    assign instr_op    = op_q;
    assign instr_imm   = imm_q;
    assign instr_pc    = ipc_q;
    assign instr_long  = long_q;
`ifdef IFETCH_HALT_EN
    assign halted      = halted_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a 256x8 synchronous-read memory model.
// Covers the HALT opcode when IFETCH_HALT_EN is defined, otherwise 8'hFF as a long op.
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       br_valid;
    logic [7:0] br_target;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_op;
    logic [7:0] instr_imm;
    logic [7:0] instr_pc;
    logic       instr_long;
`ifdef IFETCH_HALT_EN
    logic       halted;
`endif

    logic [7:0] mem [256];
    int checks;
    int errors;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_imm   (instr_imm),
        .instr_pc    (instr_pc),
`ifdef IFETCH_HALT_EN
        .halted      (halted),
`endif
        .instr_long  (instr_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory, one cycle of latency.
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for instr_valid; returns {op, imm, pc, long} and negedges waited.
    task automatic next_instr(input int budget, output logic [24:0] got,
                              output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        got = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        got = {instr_op, instr_imm, instr_pc, instr_long};
    endtask

    task automatic redirect(input logic [7:0] tgt);
        @(negedge clk);
        br_valid  = 1'b1;
        br_target = tgt;
        @(negedge clk);
        br_valid  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({instr_valid, instr_op, instr_imm, instr_pc, instr_long, mem_addr} !== 34'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b op=%h imm=%h pc=%h long=%0b addr=%h, want all zero",
                     instr_valid, instr_op, instr_imm, instr_pc, instr_long, mem_addr);
        end
    endtask

    task automatic test_sequence();
        logic [24:0] got;
        int cyc;
        bit ok;
        clear_mem();
        mem[8'h00] = 8'h12; mem[8'h01] = 8'h85; mem[8'h02] = 8'h3C; mem[8'h03] = 8'h07;
        instr_ready = 1'b1;
        do_reset();
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || cyc != 2 || got !== {8'h12, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL seq_first: got ok=%0b cyc=%0d %h, want cyc=2 %h", ok, cyc, got, {8'h12, 8'h00, 8'h00, 1'b0});
        end
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || cyc != 4 || got !== {8'h85, 8'h3C, 8'h01, 1'b1}) begin
            errors++;
            $display("FAIL seq_long: got ok=%0b cyc=%0d %h, want cyc=4 %h", ok, cyc, got, {8'h85, 8'h3C, 8'h01, 1'b1});
        end
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || cyc != 3 || got !== {8'h07, 8'h00, 8'h03, 1'b0}) begin
            errors++;
            $display("FAIL seq_third: got ok=%0b cyc=%0d %h, want cyc=3 %h", ok, cyc, got, {8'h07, 8'h00, 8'h03, 1'b0});
        end
    endtask

    task automatic test_stall();
        logic [24:0] got;
        int cyc;
        bit ok;
        instr_ready = 1'b0;
        do_reset();
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || cyc != 2 || got !== {8'h12, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL stall_first: got ok=%0b cyc=%0d %h, want cyc=2 %h", ok, cyc, got, {8'h12, 8'h00, 8'h00, 1'b0});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({instr_valid, instr_op, instr_imm, instr_pc, mem_addr} !== {1'b1, 8'h12, 8'h00, 8'h00, 8'h00}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%0b op=%h imm=%h pc=%h addr=%h, want 1/12/00/00/00",
                         i, instr_valid, instr_op, instr_imm, instr_pc, mem_addr);
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({instr_valid, mem_addr} !== {1'b0, 8'h01}) begin
            errors++;
            $display("FAIL stall_release: got v=%0b addr=%h, want v=0 addr=01", instr_valid, mem_addr);
        end
    endtask

    task automatic test_wrap();
        logic [24:0] got;
        int cyc;
        bit ok;
        clear_mem();
        mem[8'hFF] = 8'h9A; mem[8'h00] = 8'h44; mem[8'h01] = 8'h20;
        instr_ready = 1'b1;
        redirect(8'hFF);
        checks++;
        if ({instr_valid, mem_addr} !== {1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL wrap_redirect: got v=%0b addr=%h, want v=0 addr=ff", instr_valid, mem_addr);
        end
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || got !== {8'h9A, 8'h44, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL wrap_long: got ok=%0b %h, want %h", ok, got, {8'h9A, 8'h44, 8'hFF, 1'b1});
        end
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || got !== {8'h20, 8'h00, 8'h01, 1'b0}) begin
            errors++;
            $display("FAIL wrap_next: got ok=%0b %h, want %h", ok, got, {8'h20, 8'h00, 8'h01, 1'b0});
        end
    endtask

    task automatic test_branch_iml();
        logic [24:0] got;
        int cyc;
        bit ok;
        clear_mem();
        mem[8'h01] = 8'h85; mem[8'h02] = 8'h3C; mem[8'h40] = 8'h05;
        instr_ready = 1'b1;
        redirect(8'h01);
        @(negedge clk);
        checks++;
        if (mem_addr !== 8'h02) begin
            errors++;
            $display("FAIL biml_opl_addr: got %h, want 02", mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({instr_valid, mem_addr} !== {1'b0, 8'h01}) begin
            errors++;
            $display("FAIL biml_iml_addr: got v=%0b addr=%h, want v=0 addr=01", instr_valid, mem_addr);
        end
        br_valid  = 1'b1;
        br_target = 8'h40;
        @(negedge clk);
        br_valid  = 1'b0;
        checks++;
        if ({instr_valid, mem_addr} !== {1'b0, 8'h40}) begin
            errors++;
            $display("FAIL biml_redirect: got v=%0b addr=%h, want v=0 addr=40", instr_valid, mem_addr);
        end
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || got !== {8'h05, 8'h00, 8'h40, 1'b0}) begin
            errors++;
            $display("FAIL biml_next: got ok=%0b %h, want %h", ok, got, {8'h05, 8'h00, 8'h40, 1'b0});
        end
    endtask

    task automatic test_branch_handshake();
        logic [24:0] got;
        int cyc;
        bit ok;
        clear_mem();
        mem[8'h00] = 8'h12; mem[8'h10] = 8'h0A;
        instr_ready = 1'b1;
        do_reset();
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || got !== {8'h12, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL bhs_first: got ok=%0b %h, want %h", ok, got, {8'h12, 8'h00, 8'h00, 1'b0});
        end
        br_valid  = 1'b1;
        br_target = 8'h10;
        @(negedge clk);
        br_valid  = 1'b0;
        checks++;
        if ({instr_valid, mem_addr} !== {1'b0, 8'h10}) begin
            errors++;
            $display("FAIL bhs_redirect: got v=%0b addr=%h, want v=0 addr=10", instr_valid, mem_addr);
        end
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || cyc != 2 || got !== {8'h0A, 8'h00, 8'h10, 1'b0}) begin
            errors++;
            $display("FAIL bhs_next: got ok=%0b cyc=%0d %h, want cyc=2 %h", ok, cyc, got, {8'h0A, 8'h00, 8'h10, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mem_addr, instr_op, instr_pc} !== {8'h12, 8'h0A, 8'h10}) begin
            errors++;
            $display("FAIL rmid_opl: got addr=%h op=%h pc=%h, want 12/0a/10", mem_addr, instr_op, instr_pc);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({instr_valid, instr_op, instr_imm, instr_pc, instr_long, mem_addr} !== 34'h0) begin
            errors++;
            $display("FAIL rmid_clear: got v=%0b op=%h imm=%h pc=%h long=%0b addr=%h, want all zero",
                     instr_valid, instr_op, instr_imm, instr_pc, instr_long, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef IFETCH_HALT_EN
    task automatic test_halt();
        logic [24:0] got;
        int cyc;
        bit ok;
        clear_mem();
        mem[8'h00] = 8'hFF; mem[8'h40] = 8'h05;
        instr_ready = 1'b1;
        do_reset();
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || halted !== 1'b0 || got !== {8'hFF, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL halt_present: got ok=%0b halted=%0b %h, want %h", ok, halted, got, {8'hFF, 8'h00, 8'h00, 1'b0});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({halted, instr_valid, mem_addr} !== {1'b1, 1'b0, 8'h01}) begin
                errors++;
                $display("FAIL halt_hold[%0d]: got halted=%0b v=%0b addr=%h, want 1/0/01", i, halted, instr_valid, mem_addr);
            end
        end
        br_valid  = 1'b1;
        br_target = 8'h40;
        @(negedge clk);
        br_valid  = 1'b0;
        checks++;
        if ({halted, mem_addr} !== {1'b0, 8'h40}) begin
            errors++;
            $display("FAIL halt_exit: got halted=%0b addr=%h, want 0/40", halted, mem_addr);
        end
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || got !== {8'h05, 8'h00, 8'h40, 1'b0}) begin
            errors++;
            $display("FAIL halt_resume: got ok=%0b %h, want %h", ok, got, {8'h05, 8'h00, 8'h40, 1'b0});
        end
    endtask
`else
    task automatic test_ff_long();
        logic [24:0] got;
        int cyc;
        bit ok;
        clear_mem();
        mem[8'h00] = 8'hFF; mem[8'h01] = 8'h33;
        instr_ready = 1'b1;
        do_reset();
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || cyc != 3 || got !== {8'hFF, 8'h33, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL ff_long: got ok=%0b cyc=%0d %h, want cyc=3 %h", ok, cyc, got, {8'hFF, 8'h33, 8'h00, 1'b1});
        end
        next_instr(10, got, cyc, ok);
        checks++;
        if (!ok || got !== {8'h00, 8'h00, 8'h02, 1'b0}) begin
            errors++;
            $display("FAIL ff_next: got ok=%0b %h, want %h", ok, got, {8'h00, 8'h00, 8'h02, 1'b0});
        end
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        br_valid    = 1'b0;
        br_target   = 8'h00;
        instr_ready = 1'b1;
        clear_mem();
        test_reset();
        test_sequence();
        test_stall();
        test_wrap();
        test_branch_iml();
        test_branch_handshake();
        test_reset_mid();
`ifdef IFETCH_HALT_EN
        test_halt();
`else
        test_ff_long();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly downstream of the 256x8 program/data memory (synchronous read, 1-cycle latency, write-first).
- Holds the program counter, drives the memory address, and captures 1-byte and 2-byte instructions.
- Presents each complete instruction to the decoder over a valid/ready handshake.
- Accepts branch redirects from execute.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- LONG_OP_BIT, 7, opcode bit that marks a 2-byte instruction (1 = opcode + immediate byte).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  out  8  address to memory; combinational from state and PC.
- mem_rdata  in  8  memory d_o; valid one cycle after the address is presented.
- br_valid  in  1  redirect request.
- br_target  in  8  redirect PC.
- instr_valid  out  1  instruction available to the decoder.
- instr_ready  in  1  decoder accepts.
- instr_op  out  8  opcode.
- instr_imm  out  8  immediate byte; 8'h00 for 1-byte instructions.
- instr_pc  out  8  address of the opcode.
- instr_long  out  1  1 = 2-byte instruction.

Behaviour:
- Reset (asynchronous, any time, including mid-fetch):
  - pc=RESET_PC, state=S_OP.
  - instr_valid=0; instr_op, instr_imm, instr_pc = 8'h00; instr_long=0.
- States: S_OP, S_OPL, S_IML, S_OUT.
- S_OP: mem_addr=pc. Next state S_OPL.
- S_OPL: mem_addr=pc+1 (mod 256), pre-issuing the immediate read.
  - Capture mem_rdata into instr_op, pc into instr_pc.
  - If op[LONG_OP_BIT]=1: instr_long=1, go S_IML.
  - Else: instr_imm=0, instr_long=0, go S_OUT.
- S_IML: capture mem_rdata into instr_imm. Go S_OUT.
- S_OUT: instr_valid=1; instr_op, instr_imm, instr_pc and instr_long held stable while instr_ready=0.
  - On instr_valid & instr_ready: pc += 1 (short) or 2 (long), mod 256. Go S_OP.
  - instr_valid is registered and drops in the cycle after acceptance.
- Latency: from entry to S_OP, instr_valid rises 2 cycles later (short) or 3 cycles later (long). Sustained throughput is 1 short instruction per 3 cycles with instr_ready tied high.
- mem_addr in S_IML and S_OUT = pc (don't-care to memory, but defined).
- Wrap-around: a long opcode at 8'hFF reads its immediate from 8'h00; next pc = 8'h01. A short opcode at 8'hFF gives next pc = 8'h00.
- Branch, in any state: pc <= br_target, state <= S_OP, instr_valid <= 0, and any partial fetch is discarded.
- Branch with a same-cycle handshake: the transfer counts as accepted by the decoder; pc = br_target, not the sequential value.
- The memory write port is not driven by this block. A write to the address currently being read returns the new data (write-first) and is captured as-is.

Optional Feature:
- Macro: IFETCH_HALT_EN.
- Defined:
  - Opcode 8'hFF is HALT, a 1-byte instruction regardless of LONG_OP_BIT.
  - It is presented normally in S_OUT. After acceptance, the block enters S_HALT: pc is held, mem_addr=pc, instr_valid=0.
  - Extra output port halted (1 bit) = 1 in S_HALT.
  - Only br_valid or rst leaves S_HALT.
- Not defined: 8'hFF is an ordinary long instruction, and no halted port exists.

Test Plan:
- Memory 00:12, 01:85, 02:3C, 03:07; instr_ready=1; release rst → accepted, in order:
  - (op 12, imm 00, pc 00, short)
  - (op 85, imm 3C, pc 01, long)
  - (op 07, pc 03)
  - First instr_valid occurs 2 cycles after reset release.
- Same memory, instr_ready held 0 for 5 cycles at the first instruction → outputs stay 12/00/00 and valid stays 1; pc advances only on the release cycle.
- Memory FF:9A, 00:44, 01:20; pc forced to FF by br_valid=1, br_target=FF → instruction (9A, 44, pc FF, long); next instr_pc=01, op 20.
- br_valid pulse with br_target=40 during S_IML of a long instruction at 01 → that instruction is never presented; next instr_pc=40.
- br_valid=1 (target 10) in the same cycle as a handshake on op 12 → exactly one acceptance of 12; next instr_pc=10.
- rst asserted mid-S_OPL → instr_valid=0 immediately and outputs 00. With IFETCH_HALT_EN defined and memory 00:FF: after acceptance halted=1, instr_valid stays 0 for 10 cycles, mem_addr=01.
